// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: run-mode FSM, fetch PC, execute-latency counter and per-stage update codes.
// Optional EXEC-cycle / retire counters are built when PIPE_SEQ_PERF_CNT_EN is defined.
module pipe_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NSTAGE   = 3,
  parameter int unsigned     LAT_W    = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  boot_req,
  input  logic                  load_done,
  input  logic                  ack_sent,
  input  logic                  stop_in,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  jump_pend,
  input  logic [XLEN-1:0]       jump_pc,
  input  logic [LAT_W-1:0]      ex_wait,
  input  logic                  ex_busy,
  output logic [1:0]            mode,
  output logic [XLEN-1:0]       pc,
  output logic [2*NSTAGE-1:0]   upd,
  output logic                  ex_start,
  output logic [LAT_W-1:0]      lat,
  output logic [63:0]           cycle_cnt,
  output logic [63:0]           retire_cnt
);

  typedef enum logic [1:0] {
    ST_STALL = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [1:0]       UPD_HOLD  = 2'b00;
  localparam logic [1:0]       UPD_ADV   = 2'b01;
  localparam logic [1:0]       UPD_FLUSH = 2'b10;
  localparam logic [LAT_W-1:0] LAT_MAX   = '1;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt;
  logic             r_ex_start;
  logic             w_jstall, w_exec_done, w_in_exec, w_retire, w_load_entry;
  logic [1:0]       w_upd_code;

  always_comb begin
    w_jstall     = jump_pend && (r_lat == '0);
    w_exec_done  = (r_lat >= ex_wait) && !ex_busy && !w_jstall;
    w_in_exec    = (r_state == ST_EXEC);
    w_retire     = w_in_exec && w_exec_done && !redirect_valid;
    w_load_entry = (r_state == ST_STALL) && boot_req;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_lat_nxt   = r_lat;
    w_upd_code  = UPD_FLUSH;
    case (r_state)
      ST_STALL: if (boot_req) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (load_done && ack_sent) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        // stop_in only changes mode; this cycle's pc/lat action still happens
        if (stop_in) w_state_nxt = ST_STOP;
        if (redirect_valid) begin
          w_pc_nxt  = redirect_pc;
          w_lat_nxt = '0;
        end else if (w_exec_done) begin
          w_pc_nxt   = r_pc + PC_STEP;
          w_lat_nxt  = '0;
          w_upd_code = UPD_ADV;
        end else begin
          w_upd_code = UPD_HOLD;
          if (w_jstall) w_pc_nxt = jump_pc;
          if ((r_lat < ex_wait || w_jstall) && r_lat != LAT_MAX)
            w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      ST_STOP: if (boot_req) begin
        w_state_nxt = ST_STALL;
        w_pc_nxt    = RESET_PC;
        w_lat_nxt   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_STALL;
      r_pc       <= RESET_PC;
      r_lat      <= '0;
      r_ex_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_lat      <= w_lat_nxt;
      r_ex_start <= w_retire;
    end
  end

  always_comb begin
    mode     = r_state;
    pc       = r_pc;
    lat      = r_lat;
    ex_start = r_ex_start;
    upd      = {NSTAGE{w_upd_code}};
  end

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [63:0] r_cycle_cnt, r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || w_load_entry) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_in_exec) r_cycle_cnt  <= r_cycle_cnt + 64'd1;
      if (w_retire)  r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  always_comb begin
    cycle_cnt  = r_cycle_cnt;
    retire_cnt = r_retire_cnt;
  end
`else
  logic w_unused;
  always_comb begin
    cycle_cnt  = '0;
    retire_cnt = '0;
    w_unused   = w_load_entry;
  end
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed vector table, hand-built corner sequences,
// then randomized stimulus against a behavioural model.
module tb_pipe_sequencer;
  localparam int unsigned XLEN = 32, NSTAGE = 3, LAT_W = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic boot_req = 1'b0, load_done = 1'b0, ack_sent = 1'b0, stop_in = 1'b0;
  logic redirect_valid = 1'b0, jump_pend = 1'b0, ex_busy = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0, jump_pc = '0;
  logic [LAT_W-1:0] ex_wait = '0;
  logic [1:0] mode;
  logic [XLEN-1:0] pc;
  logic [2*NSTAGE-1:0] upd;
  logic ex_start;
  logic [LAT_W-1:0] lat;
  logic [63:0] cycle_cnt, retire_cnt;

  always #5 clk = ~clk;

  pipe_sequencer #(.XLEN(XLEN), .NSTAGE(NSTAGE), .LAT_W(LAT_W),
                   .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
    .clk(clk), .rstn(rstn), .boot_req(boot_req), .load_done(load_done),
    .ack_sent(ack_sent), .stop_in(stop_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .jump_pend(jump_pend), .jump_pc(jump_pc),
    .ex_wait(ex_wait), .ex_busy(ex_busy), .mode(mode), .pc(pc), .upd(upd),
    .ex_start(ex_start), .lat(lat), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));

  typedef struct {
    bit rst; bit boot; bit ld; bit ack; bit stop; bit rv; logic [31:0] rpc;
    bit jp; logic [31:0] jpc; int unsigned exw; bit busy;
    logic [5:0] e_upd; int unsigned e_mode; logic [31:0] e_pc; int unsigned e_lat; bit e_exs;
  } vec_t;

  int unsigned n_cmp = 0, n_bad = 0;

  // Behavioural model: mode 0..3, pc, latency count, counters
  int unsigned m_mode, m_lat;
  logic [31:0] m_pc;
  bit          m_exs;
  logic [63:0] m_cyc, m_ret;
`ifdef PIPE_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic vec_t mk(bit rst, bit boot, bit ld, bit ack, bit stop, bit rv,
                              logic [31:0] rpc, bit jp, logic [31:0] jpc, int unsigned exw,
                              bit busy, logic [5:0] e_upd, int unsigned e_mode,
                              logic [31:0] e_pc, int unsigned e_lat, bit e_exs);
    vec_t v;
    v.rst = rst; v.boot = boot; v.ld = ld; v.ack = ack; v.stop = stop; v.rv = rv;
    v.rpc = rpc; v.jp = jp; v.jpc = jpc; v.exw = exw; v.busy = busy;
    v.e_upd = e_upd; v.e_mode = e_mode; v.e_pc = e_pc; v.e_lat = e_lat; v.e_exs = e_exs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lat = 0; m_pc = 32'h0; m_exs = 1'b0; m_cyc = '0; m_ret = '0;
  endtask

  // One clock: drive inputs, check combinational upd, advance model, check registered state
  task automatic step(input vec_t v, input bit use_tab);
    bit blk, done;
    int unsigned code;
    logic [5:0] x_upd;
    @(negedge clk);
    rstn = !v.rst; boot_req = v.boot; load_done = v.ld; ack_sent = v.ack;
    stop_in = v.stop; redirect_valid = v.rv; redirect_pc = v.rpc;
    jump_pend = v.jp; jump_pc = v.jpc; ex_wait = LAT_W'(v.exw); ex_busy = v.busy;
    blk  = v.jp && (m_lat == 0);
    done = (m_lat >= v.exw) && !v.busy && !blk;
    if (m_mode != 2 || v.rv) code = 2;
    else if (done) code = 1;
    else code = 0;
    x_upd = 6'(code * 21);  // same 2-bit code in each of three stages
    #1 chk("upd", 64'(upd), 64'(use_tab ? v.e_upd : x_upd));
    m_exs = 1'b0;
    if (v.rst) model_reset();
    else begin
      case (m_mode)
        0: if (v.boot) begin m_mode = 1; m_cyc = '0; m_ret = '0; end
        1: if (v.ld && v.ack) m_mode = 2;
        2: begin
          m_cyc = m_cyc + 1;
          if (v.stop) m_mode = 3;
          if (v.rv) begin
            m_pc = v.rpc; m_lat = 0;
          end else if (done) begin
            m_pc = m_pc + 32'd4; m_lat = 0; m_exs = 1'b1; m_ret = m_ret + 1;
          end else begin
            if (blk) m_pc = v.jpc;
            if ((m_lat < v.exw || blk) && m_lat < 31) m_lat = m_lat + 1;
          end
        end
        default: if (v.boot) begin m_mode = 0; m_pc = 32'h0; m_lat = 0; end
      endcase
    end
    @(posedge clk);
    #1;
    chk("mode",     64'(mode),     64'(use_tab ? v.e_mode : m_mode));
    chk("pc",       64'(pc),       64'(use_tab ? v.e_pc   : m_pc));
    chk("lat",      64'(lat),      64'(use_tab ? v.e_lat  : m_lat));
    chk("ex_start", 64'(ex_start), 64'(use_tab ? v.e_exs  : m_exs));
    chk("cycle_cnt",  cycle_cnt,  PERF ? m_cyc : 64'h0);
    chk("retire_cnt", retire_cnt, PERF ? m_ret : 64'h0);
  endtask

  vec_t tab[$];
  vec_t rv_v;

  initial begin
    // reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_mode", 64'(mode), 64'h0);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_lat", 64'(lat), 64'h0);
    chk("rst_ex_start", 64'(ex_start), 64'h0);
    chk("rst_upd", 64'(upd), 64'h2A);
    chk("rst_cycle_cnt", cycle_cnt, 64'h0);
    chk("rst_retire_cnt", retire_cnt, 64'h0);

    //            rst b ld ak st rv rpc        jp jpc       exw bsy  upd   md pc         lat exs
    tab.push_back(mk(0,1,0,0,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 1, 32'h0,     0, 0));
    tab.push_back(mk(0,0,0,0,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 1, 32'h0,     0, 0));
    tab.push_back(mk(0,0,1,0,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 1, 32'h0,     0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 2, 32'h0,     0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'h4,     0, 1));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'h8,     0, 1));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'hC,     0, 1));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'h10,    0, 1));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 0,  6'h00, 2, 32'h10,    1, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 0,  6'h00, 2, 32'h10,    2, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 0,  6'h00, 2, 32'h10,    3, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 1,  6'h00, 2, 32'h10,    3, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 1,  6'h00, 2, 32'h10,    3, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    3, 0,  6'h15, 2, 32'h14,    0, 1));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      1,32'h40,   0, 0,  6'h00, 2, 32'h40,    1, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'h44,    0, 1));
    tab.push_back(mk(0,0,1,1,0,1,32'h100,    0,32'h0,    0, 0,  6'h2A, 2, 32'h100,   0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    2, 0,  6'h00, 2, 32'h100,   1, 0));
    tab.push_back(mk(0,0,1,1,0,1,32'h200,    0,32'h0,    2, 0,  6'h2A, 2, 32'h200,   0, 0));
    tab.push_back(mk(0,1,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h15, 2, 32'h204,   0, 1));
    tab.push_back(mk(0,0,1,1,1,0,32'h0,      0,32'h0,    0, 0,  6'h15, 3, 32'h208,   0, 1));
    tab.push_back(mk(0,0,0,0,0,1,32'h300,    1,32'h80,   2, 0,  6'h2A, 3, 32'h208,   0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 3, 32'h208,   0, 0));
    tab.push_back(mk(0,1,0,0,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 0, 32'h0,     0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 0, 32'h0,     0, 0));
    tab.push_back(mk(0,1,0,0,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 1, 32'h0,     0, 0));
    tab.push_back(mk(0,1,0,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 1, 32'h0,     0, 0));
    tab.push_back(mk(0,0,1,1,0,0,32'h0,      0,32'h0,    0, 0,  6'h2A, 2, 32'h0,     0, 0));
    for (int unsigned i = 0; i < tab.size(); i++) step(tab[i], 1'b1);

    // maximum ex_wait: lat climbs to 31 and holds there without wrapping
    for (int unsigned i = 1; i <= 31; i++)
      step(mk(0,0,1,1,0,0,32'h0, 0,32'h0, 31,0, 6'h00, 2, 32'h0, i, 0), 1'b1);
    step(mk(0,0,1,1,0,0,32'h0, 0,32'h0, 31,1, 6'h00, 2, 32'h0, 31, 0), 1'b1);
    step(mk(0,0,1,1,0,0,32'h0, 0,32'h0, 31,0, 6'h15, 2, 32'h4, 0, 1), 1'b1);
    step(mk(0,0,1,1,0,0,32'h0, 0,32'h0, 2,0,  6'h00, 2, 32'h4, 1, 0), 1'b1);
    // reset mid-EXEC
    step(mk(1,0,1,1,0,0,32'h0, 0,32'h0, 0,0,  6'h15, 0, 32'h0, 0, 0), 1'b1);

    for (int unsigned n = 0; n < 3000; n++) begin
      rv_v = mk($urandom_range(0,199) == 0, $urandom_range(0,5) == 0,
                $urandom_range(0,1) == 1, $urandom_range(0,1) == 1,
                $urandom_range(0,39) == 0, $urandom_range(0,7) == 0, $urandom(),
                $urandom_range(0,3) == 0, $urandom(),
                ($urandom_range(0,9) == 0) ? 31 : $urandom_range(0,4),
                $urandom_range(0,3) == 0, 6'h0, 0, 32'h0, 0, 0);
      step(rv_v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
